// File: rtl/bitserial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on start; sum/cout update only at completion, flagged by done.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit pair added per clock, cnt counts bits done
// DONE  | sum/cout freshly valid for one cycle; start here is accepted
module bitserial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s, c_nx, last;

    assign s      = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nx   = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & c);
    assign last   = (cnt == LAST);
    // Result bits so far with the current bit on top; equals the sum on the last bit.
    assign acc_nx = {s, acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? RUN : IDLE;
            RUN:        state_nx = last ? DONE : RUN;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh <= op_a;
                        b_sh <= op_b;
                        c    <= cin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    acc  <= acc_nx[WIDTH-1:1];
                    c    <= c_nx;
                    if (last) begin
                        // Explicit clear keeps non-power-of-two widths wrapping to 0.
                        cnt  <= '0;
                        sum  <= acc_nx;
                        cout <= c_nx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bitserial_adder.sv
// Directed and random checks of bitserial_adder against plain a+b+cin arithmetic,
// including latency, ignored start while busy, back-to-back ops and mid-run reset.
module tb_bitserial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    bitserial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return int'(a) + int'(b) + int'(ci);
    endfunction

    // Runs one op; on cycle 'junk' (if in 1..W) a bogus start is pulsed during RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input int junk);
        int n;
        int exp;
        int prev;
        exp   = model(a, b, ci);
        prev  = int'({cout, sum});
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            start = (n == junk);
            if (n == junk) begin
                op_a = 8'hAA;
                op_b = 8'h55;
                cin  = 1'b1;
            end else begin
                op_a = 8'($urandom);
                op_b = 8'($urandom);
                cin  = 1'($urandom);
            end
            if (!done && n <= W) begin
                chk("busy_run", int'(busy), 1);
                chk("hold_result", int'({cout, sum}), prev);
            end
        end while (!done && n < 40);
        chk("latency", n, W + 1);
        chk("result", int'({cout, sum}), exp);
        chk("busy_at_done", int'(busy), 0);
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("result_held", int'({cout, sum}), exp);
    endtask

    initial begin
        int exp_pending;
        logic [W-1:0] ra, rb;
        logic rc;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'({cout, sum}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h3C, 8'h45, 1'b0, 0);
        chk("t1_value", int'({cout, sum}), 'h081);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        chk("t2_wrap", int'({cout, sum}), 'h100);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        chk("t2_max", int'({cout, sum}), 'h1FF);

        run_op(8'h10, 8'h20, 1'b0, 4);
        chk("t3_value", int'({cout, sum}), 'h030);
        repeat (12) begin
            @(negedge clk);
            chk("t3_no_extra_done", int'(done), 0);
        end

        // Mid-run reset
        op_a  = 8'h12;
        op_b  = 8'h34;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_result", int'({cout, sum}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("t4_no_done", int'(done), 0);
        end
        run_op(8'h5A, 8'hA7, 1'b1, 0);

        // start held high: one accept every W+1 cycles
        op_a        = 8'($urandom);
        op_b        = 8'($urandom);
        cin         = 1'($urandom);
        exp_pending = model(op_a, op_b, cin);
        start       = 1'b1;
        for (int op = 0; op < 3; op++) begin
            for (int k = 1; k <= W + 1; k++) begin
                @(negedge clk);
                if (k <= W) begin
                    chk("t5_no_done", int'(done), 0);
                end else begin
                    chk("t5_done", int'(done), 1);
                    chk("t5_result", int'({cout, sum}), exp_pending);
                end
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                op_a = ra;
                op_b = rb;
                cin  = rc;
                if (k == W + 1) begin
                    exp_pending = model(ra, rb, rc);
                    if (op == 2) start = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("t5_stop", int'(busy), 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            if (i % 50 == 0) ra = 8'hFF;
            if (i % 50 == 1) rb = 8'h00;
            run_op(ra, rb, rc, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
